// File: rtl/periph_err_slave.sv
// periph_err_slave: terminating slave for the peripheral crossbar error port.
// Every access is granted (subject to an outstanding limit) and answered with
// an error response after a fixed latency. The first offending address and a
// saturating count of erroneous accesses are kept for debug, and a one-cycle
// interrupt pulse follows every grant.
module periph_err_slave #(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            DATA_WIDTH      = 32,
  parameter int unsigned            BE_WIDTH        = 4,
  parameter int unsigned            ID_WIDTH        = 9,
  parameter int unsigned            LATENCY         = 2,
  parameter int unsigned            MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA       = 32'hBADACCE5,
  parameter int unsigned            CNT_WIDTH       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic                  r_opc_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  input  logic                  clear_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  err_irq_o
);

  localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  logic [OUT_W-1:0]      r_outst_q;
  logic [OUT_W-1:0]      w_outst_next;
  logic [LATENCY-1:0]    r_pipe_vld;
  logic [ID_WIDTH-1:0]   r_pipe_id [LATENCY];
  logic                  r_err_valid;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic                  r_err_irq;
  logic                  w_rsp;
  logic                  w_gnt;
  logic                  w_xfer;
  logic                  w_unused;

  // Write data, byte enables and direction do not change the answer.
  assign w_unused = ^{wen_i, wdata_i, be_i};

  // Grant comes from registers only: a slot is free, or one frees up this cycle.
  assign w_rsp  = r_pipe_vld[LATENCY-1];
  assign w_gnt  = (r_outst_q < MAX_OUT) | w_rsp;
  assign w_xfer = req_i & w_gnt;

  // Response pipeline: valid bits shift every cycle; an ID stage only loads
  // when a valid entry enters it, so the last stage holds its ID while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) r_pipe_id[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_xfer;
      if (w_xfer) r_pipe_id[0] <= id_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        if (r_pipe_vld[i-1]) r_pipe_id[i] <= r_pipe_id[i-1];
      end
    end
  end

  // Outstanding count: +1 per transfer, -1 per response, unchanged when both.
  always_comb begin
    w_outst_next = r_outst_q;
    if (w_xfer && !w_rsp)      w_outst_next = r_outst_q + 1'b1;
    else if (!w_xfer && w_rsp) w_outst_next = r_outst_q - 1'b1;
  end

  // Outstanding count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_outst_q <= '0;
    else         r_outst_q <= w_outst_next;
  end

  // Error log: first address is sticky until clear; a transfer coinciding
  // with clear starts a fresh log with this access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end else if (w_xfer) begin
      if (!r_err_valid || clear_i) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= add_i;
      end
      if (clear_i)                           r_err_cnt <= CNT_WIDTH'(1);
      else if (r_err_cnt != {CNT_WIDTH{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
    end else if (clear_i) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end
  end

  // Interrupt pulse one cycle after each transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err_irq <= 1'b0;
    else         r_err_irq <= w_xfer;
  end

  assign gnt_o       = w_gnt;
  assign r_valid_o   = w_rsp;
  assign r_opc_o     = 1'b1;
  assign r_id_o      = r_pipe_id[LATENCY-1];
  assign r_rdata_o   = ERR_RDATA;
  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
  assign err_cnt_o   = r_err_cnt;
  assign err_irq_o   = r_err_irq;

endmodule

// File: tb/tb_periph_err_slave.sv
// Directed bench for periph_err_slave: instance a uses the default
// configuration, instance b is throttled (MAX_OUTSTANDING=1, LATENCY=3)
// with a 4-bit error counter for the saturation case.
module tb_periph_err_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a signals
  logic        a_req = 1'b0, a_wen = 1'b1, a_clear = 1'b0;
  logic [31:0] a_add = '0, a_wdata = '0;
  logic [3:0]  a_be = '0;
  logic [8:0]  a_id = '0;
  logic        a_gnt, a_rvalid, a_opc, a_evalid, a_irq;
  logic [8:0]  a_rid;
  logic [31:0] a_rdata, a_eaddr;
  logic [15:0] a_cnt;

  // instance b signals
  logic        b_req = 1'b0, b_wen = 1'b1, b_clear = 1'b0;
  logic [31:0] b_add = '0, b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic [8:0]  b_id = '0;
  logic        b_gnt, b_rvalid, b_opc, b_evalid, b_irq;
  logic [8:0]  b_rid;
  logic [31:0] b_rdata, b_eaddr;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  periph_err_slave u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .add_i(a_add), .wen_i(a_wen),
    .wdata_i(a_wdata), .be_i(a_be), .id_i(a_id), .gnt_o(a_gnt),
    .r_valid_o(a_rvalid), .r_opc_o(a_opc), .r_id_o(a_rid), .r_rdata_o(a_rdata),
    .clear_i(a_clear), .err_valid_o(a_evalid), .err_addr_o(a_eaddr),
    .err_cnt_o(a_cnt), .err_irq_o(a_irq)
  );

  periph_err_slave #(.LATENCY(3), .MAX_OUTSTANDING(1), .CNT_WIDTH(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .add_i(b_add), .wen_i(b_wen),
    .wdata_i(b_wdata), .be_i(b_be), .id_i(b_id), .gnt_o(b_gnt),
    .r_valid_o(b_rvalid), .r_opc_o(b_opc), .r_id_o(b_rid), .r_rdata_o(b_rdata),
    .clear_i(b_clear), .err_valid_o(b_evalid), .err_addr_o(b_eaddr),
    .err_cnt_o(b_cnt), .err_irq_o(b_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ngr;
    int nrsp;
    int cyc;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    #12;
    chk("rst_gnt",    32'(a_gnt), 32'd1);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rid",    32'(a_rid), 32'd0);
    chk("rst_opc",    32'(a_opc), 32'd1);
    chk("rst_rdata",  a_rdata, 32'hBADACCE5);
    chk("rst_evalid", 32'(a_evalid), 32'd0);
    chk("rst_eaddr",  a_eaddr, 32'd0);
    chk("rst_cnt",    32'(a_cnt), 32'd0);
    chk("rst_irq",    32'(a_irq), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- single access ----------------
    a_req = 1'b1; a_add = 32'h1020_0C00; a_id = 9'h004; a_wen = 1'b1;
    chk("single_gnt_T", 32'(a_gnt), 32'd1);
    chk("single_rvalid_T", 32'(a_rvalid), 32'd0);
    tick();
    a_req = 1'b0;
    $display("single: read add=0x10200c00 id=0x004 granted");
    chk("single_irq_T1", 32'(a_irq), 32'd1);
    chk("single_rvalid_T1", 32'(a_rvalid), 32'd0);
    chk("single_eaddr", a_eaddr, 32'h1020_0C00);
    chk("single_evalid", 32'(a_evalid), 32'd1);
    chk("single_cnt", 32'(a_cnt), 32'd1);
    tick();
    chk("single_irq_T2", 32'(a_irq), 32'd0);
    chk("single_rvalid_T2", 32'(a_rvalid), 32'd1);
    chk("single_rid_T2", 32'(a_rid), 32'h004);
    chk("single_opc_T2", 32'(a_opc), 32'd1);
    chk("single_rdata_T2", a_rdata, 32'hBADACCE5);
    tick();
    chk("single_rvalid_T3", 32'(a_rvalid), 32'd0);
    chk("single_rid_hold", 32'(a_rid), 32'h004);

    // ---------------- streaming ----------------
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a_req = 1'b1; a_id = 9'(1 << i); a_add = 32'h1030_0000 + 32'(i * 4);
        a_wen = i[0];
        chk($sformatf("stream_gnt%0d", i), 32'(a_gnt), 32'd1);
      end else begin
        a_req = 1'b0;
      end
      if (i >= 2) begin
        chk($sformatf("stream_rvalid%0d", i), 32'(a_rvalid), 32'd1);
        chk($sformatf("stream_rid%0d", i), 32'(a_rid), 32'(1 << (i - 2)));
      end else begin
        chk($sformatf("stream_rvalid%0d", i), 32'(a_rvalid), 32'd0);
      end
      tick();
    end
    a_req = 1'b0;
    chk("stream_drained", 32'(a_rvalid), 32'd0);
    chk("stream_cnt", 32'(a_cnt), 32'd5);
    chk("stream_eaddr_sticky", a_eaddr, 32'h1020_0C00);
    $display("stream: 4 back-to-back accesses answered in order");

    // ---------------- log sticky and clear ----------------
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clear_evalid", 32'(a_evalid), 32'd0);
    chk("clear_eaddr", a_eaddr, 32'd0);
    chk("clear_cnt", 32'(a_cnt), 32'd0);
    chk("clear_gnt", 32'(a_gnt), 32'd1);
    a_req = 1'b1; a_add = 32'h1020_1000; a_id = 9'h001; a_wen = 1'b0;
    tick();
    a_add = 32'h1030_0000; a_id = 9'h002; a_wen = 1'b1;
    chk("sticky_gnt2", 32'(a_gnt), 32'd1);
    tick();
    a_req = 1'b0;
    chk("sticky_eaddr", a_eaddr, 32'h1020_1000);
    chk("sticky_cnt", 32'(a_cnt), 32'd2);
    tick(); tick(); tick();
    a_req = 1'b1; a_clear = 1'b1; a_add = 32'h1020_2000; a_id = 9'h010;
    chk("clrx_gnt", 32'(a_gnt), 32'd1);
    tick();
    a_req = 1'b0; a_clear = 1'b0;
    chk("clrx_evalid", 32'(a_evalid), 32'd1);
    chk("clrx_eaddr", a_eaddr, 32'h1020_2000);
    chk("clrx_cnt", 32'(a_cnt), 32'd1);
    tick();
    chk("clrx_rvalid", 32'(a_rvalid), 32'd1);
    chk("clrx_rid", 32'(a_rid), 32'h010);
    tick(); tick();
    $display("log: sticky address and clear-with-transfer checked");

    // ---------------- throttle (instance b) ----------------
    nrsp = 0;
    for (int k = 0; k < 9; k++) begin
      b_req = (k < 6);
      b_id = 9'(1 << (k % 6));
      b_add = 32'h1040_0000 + 32'(k);
      if (k < 6) chk($sformatf("thr_gnt%0d", k), 32'(b_gnt), 32'((k % 3) == 0));
      chk($sformatf("thr_rvalid%0d", k), 32'(b_rvalid), 32'((k == 3) || (k == 6)));
      if (b_rvalid) begin
        nrsp++;
        chk($sformatf("thr_rid%0d", k), 32'(b_rid), (k == 3) ? 32'h001 : 32'h008);
      end
      tick();
    end
    b_req = 1'b0;
    chk("thr_nrsp", 32'(nrsp), 32'd2);
    chk("thr_cnt", 32'(b_cnt), 32'd2);
    $display("throttle: 2 grants in 6 request cycles, 2 responses");

    // ---------------- saturation (instance b) ----------------
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    chk("sat_clear_cnt", 32'(b_cnt), 32'd0);
    ngr = 0; cyc = 0;
    b_req = 1'b1;
    while (ngr < 20 && cyc < 200) begin
      b_add = 32'h1050_0000 + 32'(ngr);
      if (b_gnt) ngr++;
      tick();
      cyc++;
    end
    b_req = 1'b0;
    chk("sat_grants", 32'(ngr), 32'd20);
    chk("sat_cnt", 32'(b_cnt), 32'd15);
    chk("sat_eaddr", b_eaddr, 32'h1050_0000);
    cyc = 0;
    while (!b_gnt && cyc < 20) begin tick(); cyc++; end
    chk("sat_gnt_wait", 32'(b_gnt), 32'd1);
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    chk("sat_hold", 32'(b_cnt), 32'd15);
    $display("saturation: 4-bit count held at 15");
    tick(); tick(); tick(); tick();

    // ---------------- reset mid-flight ----------------
    a_req = 1'b1; a_add = 32'h1060_0000; a_id = 9'h080;
    chk("rmf_gnt", 32'(a_gnt), 32'd1);
    tick();
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rmf_rvalid_inrst", 32'(a_rvalid), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rmf_gnt_after", 32'(a_gnt), 32'd1);
    chk("rmf_cnt_after", 32'(a_cnt), 32'd0);
    chk("rmf_evalid_after", 32'(a_evalid), 32'd0);
    nrsp = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_rvalid) nrsp++;
      tick();
    end
    chk("rmf_no_rsp", 32'(nrsp), 32'd0);
    $display("reset mid-flight: in-flight response dropped");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
